seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-cathode seven-segment digits sharing one segment bus. Holds a BCD value for NUM_DIGITS digits, steps a one-hot digit select through them at a programmable slot rate, and drives the shared segment lines through a single digit decoder. Inserts a blanking gap between digits to prevent ghosting. Double-buffers new values so a display frame never shows a torn number.

## Interface
Parameters:
- NUM_DIGITS, 4, number of scanned digits (2..8)
- DIV, 1000, clock cycles per digit slot, blank gap included
- BLANK_CYCLES, 16, cycles at the start of each slot with all outputs off; legal range 1 ≤ BLANK_CYCLES < DIV

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load  in  1  single-cycle strobe; captures value_in into the shadow register
- value_in  in  4*NUM_DIGITS  BCD nibbles; digit 0 = value_in[3:0] = least significant
- pending  out  1  shadow holds a value not yet committed to the display
- frame_start  out  1  one-cycle pulse when a new frame (digit 0 slot) begins
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable, all zero during blanking
- segments  out  7  segment lines {a,b,c,d,e,f,g}, MSB = a, active high

## Operation
- State machine: BLANK and SHOW. A slot counter runs 0..DIV-1. A digit index runs 0..NUM_DIGITS-1.
  - BLANK covers counts 0..BLANK_CYCLES-1. SHOW covers counts BLANK_CYCLES..DIV-1.
  - At count DIV-1 the counter returns to 0, the state goes to BLANK, and the index increments. The index wraps from NUM_DIGITS-1 to 0.
- BLANK drives digit_sel = 0 and segments = 0.
- SHOW drives digit_sel = one-hot(index) and segments = decode(active nibble[index]).
- Decoder patterns:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Nibbles 10..15 force segments = 0000000. Never propagate X.
- Load and commit:
  - load=1 copies value_in to the shadow and sets pending.
  - Commit happens on the edge where the index wraps to 0 and BLANK begins. On that edge, if pending=1: active ← shadow and pending clears. frame_start pulses on the same cycle.
- Simultaneous load and commit: the commit takes the old shadow contents. The shadow then takes the new value_in and pending stays 1, so the new value commits at the following frame.
- A second load before a commit overwrites the shadow; last write wins.

## Timing
- All outputs are registered and change only on the rising edge of clk.
- Reset values:
  - digit_sel = 0, segments = 0, pending = 0, frame_start = 0.
  - State = BLANK, slot count = 0, index = 0, shadow = 0, active = 0.
- First cycle after rst deasserts is count 0 of digit 0 BLANK. No frame_start pulse for this post-reset frame.
  - First frame_start pulse comes DIV*NUM_DIGITS cycles after rst deasserts.
- In each slot, digit_sel rises on count BLANK_CYCLES, together with segments, and falls on count 0 of the next slot.
- Frame period = DIV*NUM_DIGITS cycles, exact and with no jitter.
- load to pending = 1 cycle. Commit to visible digit 0 = BLANK_CYCLES cycles.
- rst asserted mid-slot: all outputs return to reset values the next cycle. Shadow and pending are discarded.

## Configuration
- SEG7_LZ_SUPPRESS_EN defined: leading-zero suppression.
  - Digit k ≥ 1 is blanked (segments = 0) when nibble k and all higher nibbles are 0.
  - Digit 0 is always shown.
  - digit_sel timing is unchanged.
  - The blank mask is computed from active at commit and registered.
- SEG7_LZ_SUPPRESS_EN not defined: every digit is displayed, including leading zeros.

## Structure
- Shared package seg7_pkg:
  - the 7-bit segment type
  - the SEG_BLANK constant
  - the digit pattern constants
  - the state enum (BLANK, SHOW)
- One sub-module: the existing combinational BCD decoder seg7_digitsonly, instantiated once on the muxed nibble.
  - Its output is gated to zero for nibbles above 9 before the segment register.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2.
1. Reset, no load → 2 cycles with all outputs 0, then digit_sel=0001 with segments=1111110 for 6 cycles, then 2 blank cycles, then 0010; pattern repeats every 32 cycles.
2. Load 0x1234 mid-frame → pending=1 the next cycle; display unchanged until frame_start. Then digit 0 shows 0110011 and digit 3 shows 0110000; pending=0.
3. Load 0x00A9 → digit 1 slot gives segments=0000000 with digit_sel=0010; digit 0 gives 1111011.
4. Load 0x5678 on the commit edge while the shadow holds 0x1111 → frame shows 1111; the next frame shows 5678.
5. rst pulsed during a SHOW slot of digit 2 → next cycle all outputs 0; scan restarts at digit 0 BLANK; active = 0.
6. With SEG7_LZ_SUPPRESS_EN: 0x0045 → digits 3 and 2 give segments=0, digits 1 and 0 give 4 and 5. 0x0000 → only digit 0 shows 1111110.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, MSB = a, active high.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;

  typedef enum logic {BLANK, SHOW} state_t;

endpackage

// File: rtl/seg7_digitsonly.sv
// Combinational BCD digit decoder; non-decimal nibbles decode to blank.
module seg7_digitsonly
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered BCD value.
// Optional leading-zero suppression when SEG7_LZ_SUPPRESS_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic                    pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output seg_t                    segments
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BL_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  state_t        state, state_nxt;
  logic          wrap, commit;

  logic [NUM_DIGITS-1:0][3:0] shadow, active;
  logic [3:0]                 nib;
  seg_t                       dec_seg, seg_nxt;
  logic [NUM_DIGITS-1:0]      sel_nxt;
  logic                       lz_show;

  always_ff @(posedge clk) begin
    if (rst) state <= BLANK;
    else     state <= state_nxt;
  end

  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    wrap      = 1'b0;
    state_nxt = state;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      if (idx == IDX_LAST) begin
        idx_nxt = '0;
        wrap    = 1'b1;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end
    case (state)
      BLANK: if (cnt == CNT_BL_LAST) state_nxt = SHOW;
      SHOW:  if (cnt == CNT_LAST)    state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  // Commit only at the frame boundary so a frame never mixes old and new digits.
  assign commit = wrap & pending;

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] show_mask, mask_nxt;
  logic                  nz_above;

  // Bit k set when nibble k or any higher nibble of the shadow is non-zero.
  always_comb begin
    mask_nxt    = '0;
    nz_above    = 1'b0;
    mask_nxt[0] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      nz_above    = nz_above | (shadow[k] != 4'd0);
      mask_nxt[k] = nz_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         show_mask <= NUM_DIGITS'(1);
    else if (commit) show_mask <= mask_nxt;
  end

  assign lz_show = show_mask[idx_nxt];
`else
  assign lz_show = 1'b1;
`endif

  assign nib     = active[idx_nxt];
  assign sel_nxt = NUM_DIGITS'(1) << idx_nxt;

  seg7_digitsonly u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  assign seg_nxt = (nib > 4'd9 || !lz_show) ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      digit_sel   <= '0;
      segments    <= SEG_BLANK;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame_start <= wrap;
      if (commit) active <= shadow;
      // A load on the commit edge lands in the shadow and stays pending.
      if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      digit_sel <= (state_nxt == SHOW) ? sel_nxt : '0;
      segments  <= (state_nxt == SHOW) ? seg_nxt : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DV = 8;
  localparam int BC = 2;
`ifdef SEG7_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'h7E, S1 = 7'h30, S3 = 7'h79, S4 = 7'h33,
                         S5 = 7'h5B, S6 = 7'h5F, S8 = 7'h7F, S9 = 7'h7B;
  localparam logic [6:0] SZ_LZ = LZ ? 7'h00 : 7'h7E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic        pending, frame_start;
  logic [3:0]  digit_sel;
  logic [6:0]  segments;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value_in    (value_in),
    .pending     (pending),
    .frame_start (frame_start),
    .digit_sel   (digit_sel),
    .segments    (segments)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load     = 1'b1;
    value_in = v;
    step();
    load     = 1'b0;
  endtask

  task automatic disp(input string tag, input logic [3:0] sel, input logic [6:0] seg);
    chk({tag, "_sel"}, 32'(digit_sel), 32'(sel));
    chk({tag, "_seg"}, 32'(segments), 32'(seg));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // 1: idle scan from reset
    disp("rst", 4'b0000, 7'h00);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_fs", 32'(frame_start), 0);
    go(1);  disp("c1_blank", 4'b0000, 7'h00);
    go(2);  disp("c2_d0", 4'b0001, S0);
    go(7);  disp("c7_d0", 4'b0001, S0);
    go(8);  disp("c8_gap", 4'b0000, 7'h00);
    go(10); disp("c10_d1", 4'b0010, SZ_LZ);
    go(31); disp("c31_d3", 4'b1000, SZ_LZ);
            chk("c31_fs", 32'(frame_start), 0);
    go(32); chk("c32_fs", 32'(frame_start), 1);
            disp("c32_blank", 4'b0000, 7'h00);
    go(33); chk("c33_fs", 32'(frame_start), 0);

    // 2: load mid-frame, visible only after the frame boundary
    go(42); pulse_load(16'h1234);
    chk("ld1234_pend", 32'(pending), 1);
    disp("ld1234_old", 4'b0010, SZ_LZ);
    go(64); chk("c64_fs", 32'(frame_start), 1);
            chk("c64_pend", 32'(pending), 0);
    go(66); disp("1234_d0", 4'b0001, S4);
    go(74); disp("1234_d1", 4'b0010, S3);
    go(90); disp("1234_d3", 4'b1000, S1);

    // 3: non-decimal nibble blanks its digit
    pulse_load(16'h00A9);
    go(98);  disp("00a9_d0", 4'b0001, S9);
    go(106); disp("00a9_d1", 4'b0010, 7'h00);

    // 4: load coinciding with commit
    go(110); pulse_load(16'h1111);
    go(127); pulse_load(16'h5678);
    chk("c128_fs", 32'(frame_start), 1);
    chk("c128_pend", 32'(pending), 1);
    go(130); disp("1111_d0", 4'b0001, S1);
    go(154); disp("1111_d3", 4'b1000, S1);
    go(160); chk("c160_pend", 32'(pending), 0);
    go(162); disp("5678_d0", 4'b0001, S8);
    go(186); disp("5678_d3", 4'b1000, S5);

    // 5: reset mid-SHOW of digit 2 discards shadow and active
    go(200); pulse_load(16'h9999);
    go(211); disp("pre_rst_d2", 4'b0100, S6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    disp("mid_rst", 4'b0000, 7'h00);
    chk("mid_rst_pend", 32'(pending), 0);
    chk("mid_rst_fs", 32'(frame_start), 0);
    go(2);  disp("r_d0", 4'b0001, S0);
    go(10); disp("r_d1", 4'b0010, SZ_LZ);
    go(32); chk("r_c32_fs", 32'(frame_start), 1);
            chk("r_c32_pend", 32'(pending), 0);
    go(34); disp("r_c34_d0", 4'b0001, S0);

    // 6: leading zeros (suppressed only when the feature is built in)
    go(40); pulse_load(16'h0045);
    go(66); disp("0045_d0", 4'b0001, S5);
    go(74); disp("0045_d1", 4'b0010, S4);
    go(82); disp("0045_d2", 4'b0100, SZ_LZ);
    go(90); disp("0045_d3", 4'b1000, SZ_LZ);
    go(92); pulse_load(16'h0000);
    go(98);  disp("0000_d0", 4'b0001, S0);
    go(106); disp("0000_d1", 4'b0010, SZ_LZ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
